// File: rtl/cordic_arbiter_if.sv
// Operand, result and CORDIC-side handshake bundle for cordic_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/core side.
interface cordic_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 8
);
    logic                        req0_valid;
    logic [DATA_WIDTH-1:0]       req0_data;
    logic                        req0_ready;
    logic                        req1_valid;
    logic [DATA_WIDTH-1:0]       req1_data;
    logic                        req1_ready;
    logic                        res0_valid;
    logic [DATA_WIDTH-1:0]       res0_data;
    logic                        res0_ready;
    logic                        res1_valid;
    logic [DATA_WIDTH-1:0]       res1_data;
    logic                        res1_ready;
    logic [DATA_WIDTH-1:0]       cordic_in;
    logic                        cordic_valid_in;
    logic [DATA_WIDTH-1:0]       cordic_out;
    logic                        cordic_valid_out;
    logic [$clog2(TAG_DEPTH):0]  inflight;
    logic                        err_unexpected;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  res0_ready, res1_ready, cordic_out, cordic_valid_out,
        output req0_ready, req1_ready, res0_valid, res0_data, res1_valid, res1_data,
        output cordic_in, cordic_valid_in, inflight, err_unexpected
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        output res0_ready, res1_ready, cordic_out, cordic_valid_out,
        input  req0_ready, req1_ready, res0_valid, res0_data, res1_valid, res1_data,
        input  cordic_in, cordic_valid_in, inflight, err_unexpected
    );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one non-stalling CORDIC pipeline between two requesters,
// with an in-order tag FIFO steering results and credits reserving result FIFO space.
module cordic_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_DEPTH  = 4,
    parameter int TAG_DEPTH  = 8
) (
    input  logic             HCLK,
    input  logic             HRESET,
    cordic_arbiter_if.slave  bus
);
    localparam int OW = $clog2(OUT_DEPTH);
    localparam int TW = $clog2(TAG_DEPTH);
    localparam logic [OW:0] CREDIT_MAX = (OW+1)'(OUT_DEPTH);
    localparam logic [TW:0] TAG_FULL   = (TW+1)'(TAG_DEPTH);

    logic [OW:0]            credit_r   [2];
    logic                   tag_mem_r  [TAG_DEPTH];
    logic [TW:0]            tag_wr_r;
    logic [TW:0]            tag_rd_r;
    logic [DATA_WIDTH-1:0]  res_mem_r  [2][OUT_DEPTH];
    logic [OW:0]            res_wr_r   [2];
    logic [OW:0]            res_rd_r   [2];
    logic                   rr_r;
    logic [DATA_WIDTH-1:0]  cordic_in_r;
    logic                   cordic_valid_in_r;
    logic                   err_r;

    logic [TW:0]            tag_count_s;
    logic                   tag_empty_s;
    logic                   tag_pop_s;
    logic                   tag_space_s;
    logic                   tag_head_s;
    logic [1:0]             elig_s;
    logic [1:0]             grant_s;
    logic                   grant_any_s;
    logic                   grant_id_s;
    logic [DATA_WIDTH-1:0]  issue_data_s;
    logic [1:0]             res_valid_s;
    logic [1:0]             pop_s;

    assign tag_count_s  = tag_wr_r - tag_rd_r;
    assign tag_empty_s  = (tag_count_s == '0);
    assign tag_pop_s    = bus.cordic_valid_out && !tag_empty_s;
    // A full tag FIFO can still accept a push when a result retires the head this cycle.
    assign tag_space_s  = (tag_count_s != TAG_FULL) || tag_pop_s;
    assign tag_head_s   = tag_mem_r[tag_rd_r[TW-1:0]];

    assign elig_s[0]    = bus.req0_valid && (credit_r[0] != '0) && tag_space_s;
    assign elig_s[1]    = bus.req1_valid && (credit_r[1] != '0) && tag_space_s;
    assign grant_any_s  = |grant_s;
    assign grant_id_s   = grant_s[1];
    assign issue_data_s = grant_s[1] ? bus.req1_data : bus.req0_data;

    assign res_valid_s[0] = (res_wr_r[0] != res_rd_r[0]);
    assign res_valid_s[1] = (res_wr_r[1] != res_rd_r[1]);
    assign pop_s[0]       = res_valid_s[0] && bus.res0_ready;
    assign pop_s[1]       = res_valid_s[1] && bus.res1_ready;

    // Round-robin grant: the pointer port wins only when both are eligible.
    always_comb begin
        grant_s = 2'b00;
        case (elig_s)
            2'b11:   grant_s = rr_r ? 2'b10 : 2'b01;
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Control state: issue register, tag/result pointers, credits, pointer and sticky error.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            cordic_valid_in_r <= 1'b0;
            cordic_in_r       <= '0;
            tag_wr_r          <= '0;
            tag_rd_r          <= '0;
            rr_r              <= 1'b0;
            err_r             <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                credit_r[p] <= CREDIT_MAX;
                res_wr_r[p] <= '0;
                res_rd_r[p] <= '0;
            end
        end else begin
            cordic_valid_in_r <= grant_any_s;
            if (grant_any_s) begin
                cordic_in_r <= issue_data_s;
                tag_wr_r    <= tag_wr_r + 1'b1;
                rr_r        <= ~grant_id_s;
            end
            if (tag_pop_s) begin
                tag_rd_r             <= tag_rd_r + 1'b1;
                res_wr_r[tag_head_s] <= res_wr_r[tag_head_s] + 1'b1;
            end
            if (bus.cordic_valid_out && tag_empty_s) begin
                err_r <= 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
                if (pop_s[p]) begin
                    res_rd_r[p] <= res_rd_r[p] + 1'b1;
                end
                case ({grant_s[p], pop_s[p]})
                    2'b10:   credit_r[p] <= credit_r[p] - 1'b1;
                    2'b01:   credit_r[p] <= credit_r[p] + 1'b1;
                    default: credit_r[p] <= credit_r[p];
                endcase
            end
        end
    end

    // Storage arrays carry no reset; the pointers above define what is valid.
    always_ff @(posedge HCLK) begin
        if (!HRESET && grant_any_s) begin
            tag_mem_r[tag_wr_r[TW-1:0]] <= grant_id_s;
        end
        if (!HRESET && tag_pop_s) begin
            res_mem_r[tag_head_s][res_wr_r[tag_head_s][OW-1:0]] <= bus.cordic_out;
        end
    end

    assign bus.req0_ready      = grant_s[0];
    assign bus.req1_ready      = grant_s[1];
    assign bus.res0_valid      = res_valid_s[0];
    assign bus.res1_valid      = res_valid_s[1];
    assign bus.res0_data       = res_mem_r[0][res_rd_r[0][OW-1:0]];
    assign bus.res1_data       = res_mem_r[1][res_rd_r[1][OW-1:0]];
    assign bus.cordic_in       = cordic_in_r;
    assign bus.cordic_valid_in = cordic_valid_in_r;
    assign bus.inflight        = tag_count_s;
    assign bus.err_unexpected  = err_r;
endmodule

// File: tb/tb_cordic_arbiter.sv
// Randomised bench: a fixed-latency CORDIC stand-in feeds the DUT, and a negedge monitor
// compares every output against a queue-based model of issue, return and pop.
module tb_cordic_arbiter;
    localparam int DW = 32;
    localparam int OD = 4;
    localparam int TD = 8;

    logic HCLK;
    logic HRESET;
    cordic_arbiter_if #(.DATA_WIDTH(DW), .TAG_DEPTH(TD)) bus ();

    cordic_arbiter #(.DATA_WIDTH(DW), .OUT_DEPTH(OD), .TAG_DEPTH(TD)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;

    // CORDIC stand-in: a delay line of `lat` cycles applying a fixed word transform
    logic          pv [64];
    logic [DW-1:0] pd [64];
    int            lat;
    logic          spur;

    function automatic logic [DW-1:0] cfn(input logic [DW-1:0] x);
        return {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick();
        @(posedge HCLK);
        #1;
        for (int k = 63; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
        end
        pv[0] = bus.cordic_valid_in;
        pd[0] = cfn(bus.cordic_in);
        bus.cordic_valid_out = pv[lat] | spur;
        bus.cordic_out       = spur ? 32'hDEAD_BEEF : pd[lat];
    endtask

    task automatic drive(input bit v0, input bit v1, input bit r0, input bit r1);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_data  = $urandom;
        bus.req1_data  = $urandom;
        bus.res0_ready = r0;
        bus.res1_ready = r1;
    endtask

    task automatic cycles(input int n, input bit v0, input bit v1, input bit r0, input bit r1);
        for (int i = 0; i < n; i++) begin
            drive(v0, v1, r0, r1);
            tick();
        end
    endtask

    // Reference model: per-port outstanding counts, results waiting, issue-order tag queue
    int            out_cnt [2];
    int            avail   [2];
    int            tag_q   [$];
    logic [DW-1:0] exp_q0  [$];
    logic [DW-1:0] exp_q1  [$];
    int            rr_m;
    bit            err_m;
    int            prev_g;
    logic [DW-1:0] prev_d;
    int            g;
    int            p;
    bit            ret, e0, e1;
    logic [DW-1:0] want;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compare then advance the model once per cycle, between clock edges
    always @(negedge HCLK) begin
        if (HRESET) begin
            out_cnt = '{0, 0};
            avail   = '{0, 0};
            tag_q.delete();
            exp_q0.delete();
            exp_q1.delete();
            rr_m   = 0;
            err_m  = 1'b0;
            prev_g = -1;
        end else begin
            ret = bus.cordic_valid_out && (tag_q.size() > 0);
            e0  = bus.req0_valid && (out_cnt[0] < OD) && ((tag_q.size() < TD) || ret);
            e1  = bus.req1_valid && (out_cnt[1] < OD) && ((tag_q.size() < TD) || ret);
            if (e0 && e1)  g = rr_m;
            else if (e0)   g = 0;
            else if (e1)   g = 1;
            else           g = -1;

            chk("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
            chk("cordic_valid_in", 32'(bus.cordic_valid_in), 32'(prev_g >= 0));
            if (prev_g >= 0) chk("cordic_in", bus.cordic_in, prev_d);
            chk("inflight", 32'(bus.inflight), 32'(tag_q.size()));
            chk("err_unexpected", 32'(bus.err_unexpected), 32'(err_m));
            chk("res0_valid", 32'(bus.res0_valid), 32'(avail[0] > 0));
            chk("res1_valid", 32'(bus.res1_valid), 32'(avail[1] > 0));

            if (avail[0] > 0 && bus.res0_ready) begin
                want = exp_q0.pop_front();
                chk("res0_data", bus.res0_data, want);
                avail[0]--;
                out_cnt[0]--;
            end
            if (avail[1] > 0 && bus.res1_ready) begin
                want = exp_q1.pop_front();
                chk("res1_data", bus.res1_data, want);
                avail[1]--;
                out_cnt[1]--;
            end
            if (ret) begin
                p = tag_q.pop_front();
                avail[p]++;
            end else if (bus.cordic_valid_out) begin
                err_m = 1'b1;
            end
            if (g >= 0) begin
                tag_q.push_back(g);
                out_cnt[g]++;
                rr_m   = 1 - g;
                prev_d = (g == 0) ? bus.req0_data : bus.req1_data;
                if (g == 0) exp_q0.push_back(cfn(prev_d));
                else        exp_q1.push_back(cfn(bus.req1_data));
            end
            prev_g = g;
        end
    end

    initial begin
        for (int k = 0; k < 64; k++) begin
            pv[k] = 1'b0;
            pd[k] = '0;
        end
        lat    = 16;
        spur   = 1'b0;
        HRESET = 1'b1;
        bus.cordic_valid_out = 1'b0;
        bus.cordic_out       = '0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        HRESET = 1'b0;
        cycles(3, 1'b0, 1'b0, 1'b1, 1'b1);

        // single request, latency 16
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        bus.req0_data = 32'h1234_5678;
        tick();
        cycles(30, 1'b0, 1'b0, 1'b1, 1'b1);

        // contention with both requesters always valid
        cycles(16, 1'b1, 1'b1, 1'b1, 1'b1);
        cycles(30, 1'b0, 1'b0, 1'b1, 1'b1);

        // back-pressure on port 0, then a single pop
        cycles(40, 1'b1, 1'b1, 1'b0, 1'b1);
        cycles(1, 1'b1, 1'b1, 1'b1, 1'b1);
        cycles(10, 1'b1, 1'b1, 1'b0, 1'b1);
        cycles(30, 1'b0, 1'b0, 1'b1, 1'b1);

        // tag limit with a 20-cycle core
        lat = 20;
        cycles(60, 1'b1, 1'b1, 1'b1, 1'b1);
        cycles(30, 1'b0, 1'b0, 1'b1, 1'b1);

        // random traffic
        lat = 16;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 2) != 0);
            tick();
        end
        cycles(30, 1'b0, 1'b0, 1'b1, 1'b1);

        // spurious result with nothing outstanding
        spur = 1'b1;
        tick();
        spur = 1'b0;
        cycles(5, 1'b0, 1'b0, 1'b1, 1'b1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        cycles(3, 1'b0, 1'b0, 1'b1, 1'b1);

        // reset with three operands in flight; stale results then flag err_unexpected
        cycles(3, 1'b1, 1'b1, 1'b1, 1'b1);
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        cycles(25, 1'b0, 1'b0, 1'b1, 1'b1);
        cycles(12, 1'b1, 1'b1, 1'b1, 1'b1);
        cycles(30, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
